// File: rtl/ram_program_loader.sv
// Streams a program image into an async RAM, then hands the bus to the CPU.
// Optional readback check: define RAM_LOADER_VERIFY_EN.
module ram_program_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int WE_PULSE = 2
) (
  input  logic              clk,
  input  logic              master_reset,
  input  logic              load_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  output logic              ram_drive,
  input  logic [DATA_W-1:0] ram_din,
  output logic              cpu_sel,
  output logic              cpu_start,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              error
);

  localparam int CW = (WE_PULSE < 2) ? 1 : $clog2(WE_PULSE + 1);
  localparam logic [ADDR_W:0] MAXC = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [3:0] {
    IDLE, ACCEPT, SETUP, WRITE, HOLD, VERIFY,
    HANDOVER, RUN, TURN, ERROR
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_q;

`ifndef RAM_LOADER_VERIFY_EN
  logic unused_din;
  assign unused_din = ^ram_din;
`endif

  always_ff @(posedge clk) begin
    if (master_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_q     <= 1'b0;
      wr_ready   <= 1'b0;
      ram_cs_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_addr   <= '0;
      ram_dout   <= '0;
      ram_drive  <= 1'b0;
      cpu_sel    <= 1'b0;
      cpu_start  <= 1'b0;
      busy       <= 1'b0;
      word_count <= '0;
      error      <= 1'b0;
    end else begin
      cpu_start <= 1'b0;
      unique case (state)
        IDLE: if (load_start) begin
          state      <= ACCEPT;
          wr_ready   <= 1'b1;
          busy       <= 1'b1;
          word_count <= '0;
          error      <= 1'b0;
        end
        ACCEPT: if (wr_valid) begin
          state     <= SETUP;
          wr_ready  <= 1'b0;
          ram_addr  <= wr_addr;
          ram_dout  <= wr_data;
          last_q    <= wr_last;
          ram_cs_n  <= 1'b0;
          ram_drive <= 1'b1;
        end
        SETUP: begin
          state    <= WRITE;
          ram_we_n <= 1'b0;
          cnt      <= CW'(WE_PULSE - 1);
        end
        WRITE: begin
          if (cnt == '0) begin
            state    <= HOLD;
            ram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (word_count != MAXC)
            word_count <= word_count + 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
          state     <= VERIFY;
          ram_drive <= 1'b0;
          ram_oe_n  <= 1'b0;
          cnt       <= CW'(1);
`else
          ram_cs_n  <= 1'b1;
          ram_drive <= 1'b0;
          if (last_q) begin
            state <= HANDOVER;
          end else begin
            state    <= ACCEPT;
            wr_ready <= 1'b1;
          end
`endif
        end
`ifdef RAM_LOADER_VERIFY_EN
        VERIFY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ram_oe_n <= 1'b1;
            ram_cs_n <= 1'b1;
            if (ram_din != ram_dout) begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (last_q) begin
              state <= HANDOVER;
            end else begin
              state    <= ACCEPT;
              wr_ready <= 1'b1;
            end
          end
        end
        ERROR: if (load_start) begin
          state      <= ACCEPT;
          wr_ready   <= 1'b1;
          busy       <= 1'b1;
          word_count <= '0;
          error      <= 1'b0;
        end
`endif
        HANDOVER: begin
          state     <= RUN;
          cpu_sel   <= 1'b1;
          cpu_start <= 1'b1;
          busy      <= 1'b0;
        end
        // Release the CPU one cycle before the loader drives the bus.
        RUN: if (load_start) begin
          state      <= TURN;
          cpu_sel    <= 1'b0;
          busy       <= 1'b1;
          word_count <= '0;
          error      <= 1'b0;
        end
        TURN: begin
          state    <= ACCEPT;
          wr_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
